pdm_cic_array: RTL



---
 rtl/pdm_pkg.sv | 29 ++
 rtl/pdm_cic_array_cic.sv | 79 +++++++
 rtl/pdm_cic_array.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM microphone CIC front end.
// Defining PDM_DDR_EN puts two microphones on each PDM line, one per pdm_clk phase.
package pdm_pkg;

`ifdef PDM_DDR_EN
  localparam int CH_PER_LINE = 2;
`else
  localparam int CH_PER_LINE = 1;
`endif

  typedef enum logic {IDLE, SEND} rd_state_t;

  function automatic int acc_width(input int order, input int decim);
    return order * $clog2(decim) + 1;
  endfunction

  // v is the exact comb result, which can reach +2^(acc_w-1). The value is
  // clamped to the signed acc_w range, then its top out_w bits are returned.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int acc_w, input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] s;
    max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    s = (v > max_v) ? max_v : v;
    if (out_w >= acc_w) return s <<< (out_w - acc_w);
    return s >>> (acc_w - out_w);
  endfunction

endpackage

// File: rtl/pdm_cic_array_cic.sv
// One CIC decimator channel: integrators on samp_stb, combs on dec_stb, then saturate and scale.
// pcm changes only in the cycle after a dec_stb.
module cic_channel
  import pdm_pkg::*;
#(
  parameter int CIC_ORDER = 4,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 samp_stb,
  input  logic                 samp_bit,
  input  logic                 dec_stb,
  output logic [OUT_WIDTH-1:0] pcm
);
  localparam int ACC_W = acc_width(CIC_ORDER, DECIM);
  typedef logic signed [ACC_W-1:0] acc_t;
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  acc_t integ     [CIC_ORDER];
  acc_t integ_nxt [CIC_ORDER];
  acc_t dly       [CIC_ORDER];
  acc_t comb_in   [CIC_ORDER];
  acc_t comb_res;
  acc_t comb_out;
  logic last_bit;
  logic out_pos;

  always_comb begin
    acc_t run;
    run = samp_bit ? acc_t'(1) : '1;
    for (int k = 0; k < CIC_ORDER; k++) begin
      run = integ[k] + run;
      integ_nxt[k] = run;
    end
  end

  always_comb begin
    acc_t c;
    c = integ[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      comb_in[k] = c;
      c = c - dly[k];
    end
    comb_res = c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
      comb_out <= '0;
      last_bit <= 1'b0;
      out_pos  <= 1'b0;
    end else begin
      if (samp_stb) begin
        for (int k = 0; k < CIC_ORDER; k++) integ[k] <= integ_nxt[k];
        last_bit <= samp_bit;
      end
      if (dec_stb) begin
        for (int k = 0; k < CIC_ORDER; k++) dly[k] <= comb_in[k];
        comb_out <= comb_res;
        out_pos  <= last_bit;
      end
    end
  end

  // +full-scale wraps onto ACC_MIN; both extremes need a uniform input window,
  // so the newest sample tells which one this is.
  always_comb begin
    logic signed [63:0] v;
    v = (out_pos && comb_out == ACC_MIN) ? (64'sd1 <<< (ACC_W - 1)) : 64'(comb_out);
    pcm = OUT_WIDTH'(sat_trunc(v, ACC_W, OUT_WIDTH));
  end

endmodule

// File: rtl/pdm_cic_array.sv
// Multi-mic PDM clock gen, CIC decimation, frame FIFO and per-channel PCM readout (PDM_DDR_EN: 2 mics/line).
// Frame to pcm_valid in 2 clk when FIFO empty; full FIFO drops new frames and counts them.
module pdm_cic_array
  import pdm_pkg::*;
#(
  parameter int NUM_MICS   = 9,
  parameter int CLK_DIV    = 12,
  parameter int DECIM      = 64,
  parameter int CIC_ORDER  = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_MICS-1:0]                       pdm,
  output logic                                      pdm_clk,
  output logic [OUT_WIDTH-1:0]                      pcm_data,
  output logic [$clog2(CH_PER_LINE*NUM_MICS)-1:0]   pcm_chan,
  output logic                                      pcm_last,
  output logic                                      pcm_valid,
  input  logic                                      pcm_ready,
  output logic [15:0]                               overflow_cnt
);
  localparam int NCH   = CH_PER_LINE * NUM_MICS;
  localparam int CH_W  = $clog2(NCH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SMP_W = $clog2(DECIM);
  localparam int WRM_W = $clog2(CIC_ORDER + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
  localparam logic [WRM_W-1:0] WRM_DONE = WRM_W'(CIC_ORDER);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_end;
  logic [NCH-1:0]   line_bits;
  logic [NCH-1:0]   samp_bits;
  logic             samp_stb;
  logic [SMP_W-1:0] samp_cnt;
  logic             dec_stb;
  logic [WRM_W-1:0] warm_cnt;
  logic             frame_vld;
  logic [NCH-1:0][OUT_WIDTH-1:0] frame_dat;

  assign phase_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      pdm_clk <= ~pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef PDM_DDR_EN
  logic [NUM_MICS-1:0] lo_bits;

  always_ff @(posedge clk) begin
    if (rst) lo_bits <= '0;
    else if (phase_end && !pdm_clk) lo_bits <= pdm;
  end

  // Both mics on a line advance together on the high-phase strobe.
  always_comb begin
    line_bits = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      line_bits[2*i]   = pdm[i];
      line_bits[2*i+1] = lo_bits[i];
    end
  end
`else
  assign line_bits = pdm;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_stb  <= 1'b0;
      samp_bits <= '0;
      samp_cnt  <= '0;
      dec_stb   <= 1'b0;
      warm_cnt  <= '0;
      frame_vld <= 1'b0;
    end else begin
      samp_stb <= phase_end && pdm_clk;
      if (phase_end && pdm_clk) samp_bits <= line_bits;
      dec_stb <= samp_stb && (&samp_cnt);
      if (samp_stb) samp_cnt <= samp_cnt + SMP_W'(1);
      frame_vld <= dec_stb && (warm_cnt == WRM_DONE);
      if (dec_stb && warm_cnt != WRM_DONE) warm_cnt <= warm_cnt + WRM_W'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    cic_channel #(
      .CIC_ORDER(CIC_ORDER),
      .DECIM    (DECIM),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .samp_stb(samp_stb),
      .samp_bit(samp_bits[c]),
      .dec_stb (dec_stb),
      .pcm     (frame_dat[c])
    );
  end

  logic [NCH-1:0][OUT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt, fifo_cnt_nxt;
  logic             push, pop, ovf;
  rd_state_t        state, state_nxt;
  logic [CH_W-1:0]  chan, chan_nxt;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    pop          = (state == SEND) && pcm_ready && (chan == CH_LAST);
    push         = frame_vld && ((fifo_cnt != FULL_CNT) || pop);
    ovf          = frame_vld && !push;
    fifo_cnt_nxt = fifo_cnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    state_nxt    = state;
    chan_nxt     = chan;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          state_nxt = SEND;
          chan_nxt  = '0;
        end
      end
      SEND: begin
        if (pcm_ready) begin
          if (chan == CH_LAST) begin
            chan_nxt = '0;
            if (fifo_cnt_nxt == '0) state_nxt = IDLE;
          end else begin
            chan_nxt = chan + CH_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      chan         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      overflow_cnt <= '0;
    end else begin
      state    <= state_nxt;
      chan     <= chan_nxt;
      fifo_cnt <= fifo_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (ovf && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= frame_dat;
  end

  assign pcm_valid = (state == SEND);
  assign pcm_chan  = chan;
  assign pcm_last  = pcm_valid && (chan == CH_LAST);
  assign pcm_data  = pcm_valid ? fifo_mem[rd_ptr][chan] : '0;

endmodule
